// File: rtl/sht21_scheduler.sv
// Measurement sequencer for an SHT21 sensor behind a byte-oriented IIC controller:
// triggers a temperature then a humidity transaction, validates status bits, reports result.
module sht21_scheduler #(
   parameter int unsigned PERIOD_CYC  = 25_000_000,
   parameter int unsigned TIMEOUT_CYC = 2_500_000,
   parameter int unsigned GAP_CYC     = 1024,
   parameter logic [6:0]  DEV_ADDR    = 7'h40
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        auto_en,
   input  logic        start,
   output logic        iic_en,
   output logic [7:0]  dev_wradd,
   output logic [7:0]  dev_rdadd,
   output logic [7:0]  dev_sdcmd,
   input  logic [7:0]  iic_rdms,
   input  logic [7:0]  iic_rdls,
   input  logic        iic_ack,
   output logic [13:0] temp_raw,
   output logic [11:0] hum_raw,
   output logic        done,
   output logic [1:0]  err_code,
   output logic        busy
);

   localparam int unsigned PER_W = ($clog2(PERIOD_CYC) > 25) ? $clog2(PERIOD_CYC) : 25;
   localparam int unsigned TO_W  = ($clog2(TIMEOUT_CYC) > 22) ? $clog2(TIMEOUT_CYC) : 22;
   localparam int unsigned GAP_W = ($clog2(GAP_CYC) > 11) ? $clog2(GAP_CYC) : 11;

   localparam logic [PER_W-1:0] PER_LAST = PER_W'(PERIOD_CYC - 1);
   localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYC - 1);
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYC - 1);

   localparam logic [7:0] CMD_TEMP = 8'hE3;
   localparam logic [7:0] CMD_HUM  = 8'hE5;

   localparam logic [1:0] ERR_OK       = 2'b00;
   localparam logic [1:0] ERR_TIMEOUT  = 2'b01;
   localparam logic [1:0] ERR_MISMATCH = 2'b10;

   typedef enum logic [2:0] {
      S_IDLE, S_TRIG_T, S_WAIT_T, S_GAP, S_TRIG_H, S_WAIT_H, S_DONE
   } state_t;

   state_t           state_q, state_d;
   logic [PER_W-1:0] per_cnt_q, per_cnt_d;
   logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
   logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
   logic             iic_ack_d_q;
   logic [1:0]       err_rec_q, err_rec_d;
   logic             iic_en_q, iic_en_d;
   logic             done_q, done_d;
   logic             busy_q, busy_d;
   logic [1:0]       err_code_q, err_code_d;
   logic [13:0]      temp_q, temp_d;
   logic [11:0]      hum_q, hum_d;
   logic [7:0]       sdcmd_q, sdcmd_d;
   logic             ack_rise;

   assign ack_rise = iic_ack & ~iic_ack_d_q;

   always_comb begin
      state_d    = state_q;
      per_cnt_d  = '0;
      to_cnt_d   = to_cnt_q;
      gap_cnt_d  = gap_cnt_q;
      err_rec_d  = err_rec_q;
      temp_d     = temp_q;
      hum_d      = hum_q;
      err_code_d = err_code_q;

      case (state_q)
         S_IDLE: begin
            if (start || (auto_en && per_cnt_q == PER_LAST)) begin
               state_d   = S_TRIG_T;
               err_rec_d = ERR_OK;
            end else if (auto_en) begin
               // Reaching PER_LAST always leaves IDLE, so the count never passes it.
               per_cnt_d = per_cnt_q + 1'b1;
            end
         end
         S_TRIG_T: begin
            state_d  = S_WAIT_T;
            to_cnt_d = '0;
         end
         S_WAIT_T: begin
            if (ack_rise) begin
               if (!iic_rdls[1]) temp_d = {iic_rdms, iic_rdls[7:2]};
               else              err_rec_d = ERR_MISMATCH;
               state_d   = S_GAP;
               gap_cnt_d = '0;
            end else if (to_cnt_q == TO_LAST) begin
               state_d   = S_DONE;
               err_rec_d = ERR_TIMEOUT;
            end else begin
               to_cnt_d = to_cnt_q + 1'b1;
            end
         end
         S_GAP: begin
            // Counting only starts once the controller has dropped its ack.
            if (gap_cnt_q == '0 && iic_ack) begin
               state_d = S_GAP;
            end else if (gap_cnt_q == GAP_LAST) begin
               state_d   = S_TRIG_H;
               gap_cnt_d = '0;
            end else begin
               gap_cnt_d = gap_cnt_q + 1'b1;
            end
         end
         S_TRIG_H: begin
            state_d  = S_WAIT_H;
            to_cnt_d = '0;
         end
         S_WAIT_H: begin
            if (ack_rise) begin
               if (iic_rdls[1]) hum_d = {iic_rdms, iic_rdls[7:4]};
               else             err_rec_d = ERR_MISMATCH;
               state_d = S_DONE;
            end else if (to_cnt_q == TO_LAST) begin
               state_d   = S_DONE;
               err_rec_d = ERR_TIMEOUT;
            end else begin
               to_cnt_d = to_cnt_q + 1'b1;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (state_d == S_DONE) err_code_d = err_rec_d;

      iic_en_d = (state_d == S_TRIG_T) || (state_d == S_TRIG_H);
      done_d   = (state_d == S_DONE);
      busy_d   = (state_d != S_IDLE);
      sdcmd_d  = ((state_d == S_TRIG_H) || (state_d == S_WAIT_H)) ? CMD_HUM : CMD_TEMP;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         per_cnt_q   <= '0;
         to_cnt_q    <= '0;
         gap_cnt_q   <= '0;
         iic_ack_d_q <= 1'b0;
         err_rec_q   <= ERR_OK;
         iic_en_q    <= 1'b0;
         done_q      <= 1'b0;
         busy_q      <= 1'b0;
         err_code_q  <= ERR_OK;
         temp_q      <= '0;
         hum_q       <= '0;
         sdcmd_q     <= CMD_TEMP;
      end else begin
         state_q     <= state_d;
         per_cnt_q   <= per_cnt_d;
         to_cnt_q    <= to_cnt_d;
         gap_cnt_q   <= gap_cnt_d;
         iic_ack_d_q <= iic_ack;
         err_rec_q   <= err_rec_d;
         iic_en_q    <= iic_en_d;
         done_q      <= done_d;
         busy_q      <= busy_d;
         err_code_q  <= err_code_d;
         temp_q      <= temp_d;
         hum_q       <= hum_d;
         sdcmd_q     <= sdcmd_d;
      end
   end

   assign dev_wradd = {DEV_ADDR, 1'b0};
   assign dev_rdadd = {DEV_ADDR, 1'b1};
   assign dev_sdcmd = sdcmd_q;
   assign iic_en    = iic_en_q;
   assign done      = done_q;
   assign busy      = busy_q;
   assign err_code  = err_code_q;
   assign temp_raw  = temp_q;
   assign hum_raw   = hum_q;

endmodule

// File: tb/tb_sht21_scheduler.sv
// Bench for sht21_scheduler: a reactive IIC controller stand-in, a command scoreboard,
// a vector table checked against a reference model, and hand-written corner sequences.
module tb_sht21_scheduler;

   localparam int PERIOD  = 5000;
   localparam int TIMEOUT = 1000;
   localparam int GAP     = 16;
   localparam int NV      = 10;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        auto_en = 1'b0;
   logic        start = 1'b0;
   logic        iic_en;
   logic [7:0]  dev_wradd, dev_rdadd, dev_sdcmd;
   logic [7:0]  iic_rdms, iic_rdls;
   logic        iic_ack;
   logic [13:0] temp_raw;
   logic [11:0] hum_raw;
   logic        done;
   logic [1:0]  err_code;
   logic        busy;

   sht21_scheduler #(
      .PERIOD_CYC (PERIOD),
      .TIMEOUT_CYC(TIMEOUT),
      .GAP_CYC    (GAP),
      .DEV_ADDR   (7'h40)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .auto_en  (auto_en),
      .start    (start),
      .iic_en   (iic_en),
      .dev_wradd(dev_wradd),
      .dev_rdadd(dev_rdadd),
      .dev_sdcmd(dev_sdcmd),
      .iic_rdms (iic_rdms),
      .iic_rdls (iic_rdls),
      .iic_ack  (iic_ack),
      .temp_raw (temp_raw),
      .hum_raw  (hum_raw),
      .done     (done),
      .err_code (err_code),
      .busy     (busy)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- bookkeeping ----------------
   int checks = 0;
   int errors = 0;
   int en_cnt = 0;
   int done_cnt = 0;
   int last_en_cyc = 0;
   int last_done_cyc = 0;
   int t_fall_cyc = 0;
   logic [1:0] done_err = 2'b00;
   logic [7:0] exp_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   logic [13:0] m_temp = '0;
   logic [11:0] m_hum = '0;

   task automatic ref_meas(input logic [7:0] tms, input logic [7:0] tls,
                           input logic [7:0] hms, input logic [7:0] hls,
                           output logic [1:0] err);
      err = 2'b00;
      if (((tls >> 1) & 1) == 0) m_temp = 14'(tms * 64 + tls / 4);
      else                       err = 2'b10;
      if (((hls >> 1) & 1) == 1) m_hum = 12'(hms * 16 + hls / 16);
      else                       err = 2'b10;
   endtask

   // ---------------- controller stand-in ----------------
   logic       rsp_on = 1'b0;
   int         rsp_delay = 2;
   int         rsp_hold = 3;
   logic [7:0] rsp_tms = '0, rsp_tls = '0, rsp_hms = '0, rsp_hls = '0;

   initial begin
      logic is_h;
      iic_ack  = 1'b0;
      iic_rdms = '0;
      iic_rdls = '0;
      forever begin
         @(negedge clk);
         if (iic_en && rsp_on) begin
            is_h = (dev_sdcmd == 8'hE5);
            repeat (rsp_delay) @(negedge clk);
            iic_rdms = is_h ? rsp_hms : rsp_tms;
            iic_rdls = is_h ? rsp_hls : rsp_tls;
            iic_ack  = 1'b1;
            repeat (rsp_hold) @(negedge clk);
            iic_ack = 1'b0;
            if (!is_h) t_fall_cyc = cyc;
         end
      end
   end

   // ---------------- monitor / command scoreboard ----------------
   always @(negedge clk) begin
      logic [7:0] exp_cmd;
      if (iic_en) begin
         en_cnt++;
         last_en_cyc = cyc;
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_iic_en: cmd 0x%0h while no transaction expected", dev_sdcmd);
         end else begin
            exp_cmd = exp_q.pop_front();
            check("iic_en_cmd", dev_sdcmd, exp_cmd);
         end
      end
      if (done) begin
         done_cnt++;
         last_done_cyc = cyc;
         done_err = err_code;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic pulse_start();
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      #1;
   endtask

   task automatic wait_done(input string tag, input int limit);
      int n = 0;
      int d0 = done_cnt;
      while (done_cnt == d0 && n < limit) begin
         @(negedge clk); #1;
         n++;
      end
      check({tag, "_done_seen"}, (done_cnt != d0), 1);
   endtask

   task automatic wait_en(input string tag, input int target, input int limit);
      int n = 0;
      while (en_cnt < target && n < limit) begin
         @(negedge clk); #1;
         n++;
      end
      check({tag, "_en_seen"}, (en_cnt >= target), 1);
   endtask

   task automatic run_meas(input string tag,
                           input logic [7:0] tms, input logic [7:0] tls,
                           input logic [7:0] hms, input logic [7:0] hls,
                           input int dly, input int hold,
                           input logic [13:0] et, input logic [11:0] eh, input logic [1:0] ee);
      int en0;
      rsp_tms = tms; rsp_tls = tls; rsp_hms = hms; rsp_hls = hls;
      rsp_delay = dly; rsp_hold = hold; rsp_on = 1'b1;
      en0 = en_cnt;
      exp_q.push_back(8'hE3);
      exp_q.push_back(8'hE5);
      pulse_start();
      check({tag, "_busy"}, busy, 1);
      wait_done(tag, 3000);
      check({tag, "_temp"}, temp_raw, et);
      check({tag, "_hum"}, hum_raw, eh);
      check({tag, "_err"}, done_err, ee);
      check({tag, "_en_pulses"}, en_cnt - en0, 2);
      repeat (hold + 2) @(negedge clk);
      #1;
      check({tag, "_idle"}, busy, 0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_iic_en"}, iic_en, 0);
      check({tag, "_done"}, done, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_err"}, err_code, 0);
      check({tag, "_temp"}, temp_raw, 0);
      check({tag, "_hum"}, hum_raw, 0);
      check({tag, "_sdcmd"}, dev_sdcmd, 8'hE3);
      check({tag, "_wradd"}, dev_wradd, 8'h80);
      check({tag, "_rdadd"}, dev_rdadd, 8'h81);
   endtask

   // ---------------- test sequence ----------------
   typedef struct {
      logic [7:0]  tms, tls, hms, hls;
      logic [13:0] exp_temp;
      logic [11:0] exp_hum;
      logic [1:0]  exp_err;
   } vec_t;

   vec_t v[NV];

   initial begin
      logic [1:0] ee;
      int snap, d1, e0;

      // Vector table: two fixed cases, then random bytes with model-derived expectations.
      v[0] = '{8'h66, 8'h7C, 8'h7A, 8'h42, 14'h199F, 12'h7A4, 2'b00};
      v[1] = '{8'h12, 8'h7E, 8'h55, 8'h3A, 14'h199F, 12'h553, 2'b10};
      ref_meas(v[0].tms, v[0].tls, v[0].hms, v[0].hls, ee);
      ref_meas(v[1].tms, v[1].tls, v[1].hms, v[1].hls, ee);
      for (int i = 2; i < NV; i++) begin
         v[i].tms = 8'($urandom_range(0, 255));
         v[i].tls = 8'($urandom_range(0, 255));
         v[i].hms = 8'($urandom_range(0, 255));
         v[i].hls = 8'($urandom_range(0, 255));
         ref_meas(v[i].tms, v[i].tls, v[i].hms, v[i].hls, ee);
         v[i].exp_temp = m_temp;
         v[i].exp_hum  = m_hum;
         v[i].exp_err  = ee;
      end

      // Reset state
      repeat (3) @(negedge clk);
      #1;
      check_reset_outputs("reset");
      @(negedge clk); rst_n = 1'b1;
      repeat (3) @(negedge clk);

      for (int i = 0; i < NV; i++)
         run_meas($sformatf("vec%0d", i), v[i].tms, v[i].tls, v[i].hms, v[i].hls, 2, 3,
                  v[i].exp_temp, v[i].exp_hum, v[i].exp_err);

      // Long ack: one capture, and humidity trigger GAP cycles after ack falls.
      ref_meas(8'h40, 8'h10, 8'h33, 8'hF2, ee);
      run_meas("long_ack", 8'h40, 8'h10, 8'h33, 8'hF2, 3, 50, m_temp, m_hum, ee);
      check("long_ack_gap", last_en_cyc - t_fall_cyc, GAP);

      // Timeout: controller never answers.
      rsp_on = 1'b0;
      exp_q.push_back(8'hE3);
      snap = en_cnt + 1;
      pulse_start();
      wait_en("timeout", snap, 50);
      e0 = last_en_cyc;
      wait_done("timeout", TIMEOUT + 500);
      check("timeout_latency", last_done_cyc - e0, TIMEOUT + 1);
      check("timeout_err", done_err, 2'b01);
      check("timeout_temp_kept", temp_raw, m_temp);
      check("timeout_hum_kept", hum_raw, m_hum);
      check("timeout_en_pulses", en_cnt - (snap - 1), 1);
      @(negedge clk); #1;
      check("timeout_idle", busy, 0);

      // Auto mode with a start pulse while busy.
      rsp_tms = 8'h66; rsp_tls = 8'h7C; rsp_hms = 8'h7A; rsp_hls = 8'h42;
      rsp_delay = 1; rsp_hold = 1; rsp_on = 1'b1;
      ref_meas(8'h66, 8'h7C, 8'h7A, 8'h42, ee);
      repeat (4) exp_q.push_back(8'hE3);
      exp_q.delete();
      exp_q.push_back(8'hE3); exp_q.push_back(8'hE5);
      exp_q.push_back(8'hE3); exp_q.push_back(8'hE5);
      @(negedge clk); auto_en = 1'b1;
      wait_en("auto1", en_cnt + 1, PERIOD + 100);
      pulse_start();
      wait_done("auto1", 2000);
      d1 = last_done_cyc;
      check("auto1_err", done_err, ee);
      wait_en("auto2", en_cnt + 1, PERIOD + 100);
      // IDLE spans exactly PERIOD cycles between DONE and the next trigger.
      check("auto_period", last_en_cyc - d1, PERIOD + 1);
      @(negedge clk); auto_en = 1'b0;
      wait_done("auto2", 2000);
      check("auto2_err", done_err, ee);
      check("auto2_temp", temp_raw, 14'h199F);
      check("auto2_hum", hum_raw, 12'h7A4);
      snap = en_cnt;
      repeat (300) @(negedge clk);
      #1;
      check("auto_off_quiet", en_cnt, snap);

      // Reset while waiting for the humidity ack.
      rsp_delay = 30; rsp_hold = 2;
      exp_q.push_back(8'hE3); exp_q.push_back(8'hE5);
      snap = en_cnt + 2;
      pulse_start();
      wait_en("rst_mid", snap, 200);
      repeat (5) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_reset_outputs("rst_mid");
      snap = done_cnt;
      repeat (40) @(negedge clk);
      #1;
      check("rst_mid_no_done", done_cnt, snap);
      @(negedge clk); rst_n = 1'b1;
      m_temp = '0;
      m_hum  = '0;
      repeat (3) @(negedge clk);
      ref_meas(8'h66, 8'h7C, 8'h7A, 8'h42, ee);
      run_meas("after_rst", 8'h66, 8'h7C, 8'h7A, 8'h42, 2, 3, m_temp, m_hum, ee);

      check("cmd_queue_drained", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/sht21_scheduler.md
SHT21_SCHEDULER -- requirements
Module: sht21_scheduler

Interface
REQ-001 The module SHALL provide parameter PERIOD_CYC, default 25_000_000, clk cycles between auto-mode measurement starts (1 s at 25 MHz).
REQ-002 The module SHALL provide parameter TIMEOUT_CYC, default 2_500_000, maximum clk cycles spent waiting for one transaction's iic_ack.
REQ-003 The module SHALL provide parameter GAP_CYC, default 1024, idle clk cycles between the temperature and humidity transactions.
REQ-004 The module SHALL provide parameter DEV_ADDR, default 7'h40, the 7-bit sensor address.
REQ-005 The ports SHALL be:
- clk  in  1  system clock; one clock domain
- rst_n  in  1  asynchronous, active-low reset
- auto_en  in  1  periodic measurement enable
- start  in  1  single-shot request pulse
- iic_en  out  1  one-cycle transaction trigger to the IIC controller
- dev_wradd  out  8  write address, constant {DEV_ADDR,1'b0} (0x80)
- dev_rdadd  out  8  read address, constant {DEV_ADDR,1'b1} (0x81)
- dev_sdcmd  out  8  sensor command: 0xE3 (temperature) or 0xE5 (humidity)
- iic_rdms  in  8  controller read MSB
- iic_rdls  in  8  controller read LSB
- iic_ack  in  1  controller completion level; high while the controller is in STOP
- temp_raw  out  14  last valid temperature code
- hum_raw  out  12  last valid humidity code
- done  out  1  one-cycle end-of-measurement pulse
- err_code  out  2  result status, valid with done: 00 ok, 01 timeout, 10 status-bit mismatch
- busy  out  1  high from leaving IDLE until done

Function
REQ-006 The module SHALL register iic_ack once and use ack_rise = iic_ack & ~iic_ack_d as the only completion event, so that one capture happens per high level of any length.
REQ-007 The FSM SHALL have states IDLE, TRIG_T, WAIT_T, GAP, TRIG_H, WAIT_H and DONE.
REQ-008 IDLE SHALL go to TRIG_T when start=1, or when auto_en=1 and the period counter equals PERIOD_CYC-1.
REQ-009 TRIG_T and TRIG_H SHALL each last exactly one cycle, with iic_en=1 in that cycle only, and then go to WAIT_T and WAIT_H respectively.
REQ-010 dev_sdcmd SHALL be 0xE3 in IDLE, TRIG_T, WAIT_T and GAP, and 0xE5 in TRIG_H and WAIT_H, and SHALL be held stable throughout each transaction.
REQ-011 WAIT_T on ack_rise SHALL check iic_rdls[1]:
- if iic_rdls[1]==0, load temp_raw={iic_rdms, iic_rdls[7:2]}
- otherwise, record mismatch (err 10) and leave temp_raw unchanged
- in both cases, go to GAP.
REQ-012 GAP SHALL wait until iic_ack==0 and then count GAP_CYC cycles before going to TRIG_H; this lets the controller return to its idle state.
REQ-013 WAIT_H on ack_rise SHALL check iic_rdls[1]:
- if iic_rdls[1]==1, load hum_raw={iic_rdms, iic_rdls[7:4]}
- otherwise, record mismatch (err 10) and leave hum_raw unchanged
- in both cases, go to DONE.
REQ-014 A timeout counter SHALL clear on entering WAIT_T or WAIT_H. If it reaches TIMEOUT_CYC-1 without ack_rise, the FSM SHALL go directly to DONE with err 01, skipping any remaining transaction.
REQ-015 If timeout and mismatch both occur in one measurement, err_code SHALL be 01 (timeout has priority).
REQ-016 DONE SHALL last one cycle, assert done=1, present err_code, and return to IDLE; the internal error record SHALL clear on leaving IDLE.
REQ-017 busy SHALL be 1 in every state except IDLE.
REQ-018 start asserted while busy=1 SHALL be ignored and not queued.
REQ-019 The period counter SHALL behave as follows:
- hold 0 while auto_en=0
- clear to 0 when the FSM leaves IDLE
- increment each cycle in IDLE when auto_en=1
- saturate at PERIOD_CYC-1.
REQ-020 The period counter SHALL be at least 25 bits wide; the timeout counter at least 22 bits; the gap counter at least 11 bits.

Reset
REQ-021 While rst_n=0, the module SHALL asynchronously force:
- FSM=IDLE and all counters=0
- iic_ack_d=0
- iic_en=0, done=0, busy=0
- err_code=00, temp_raw=0, hum_raw=0
- dev_sdcmd=0xE3
REQ-022 Reset asserted mid-measurement SHALL abort the measurement with no done pulse, and operation SHALL resume from IDLE after release.

Verification
REQ-023 Nominal: start pulse; the model acks temperature with rdms=0x66, rdls=0x7C and humidity with rdms=0x7A, rdls=0x42 -> exactly two iic_en pulses, temp_raw=0x199F, hum_raw=0x7A4, done pulse with err_code=00.
REQ-024 Mismatch: temperature rdls=0x7E, previous temp_raw=0x199F -> temp_raw stays 0x199F, the humidity transaction still runs, done with err_code=10.
REQ-025 Timeout: start with no ack and TIMEOUT_CYC=1000 -> one iic_en pulse, then done with err_code=01 exactly 1000 cycles after WAIT_T entry, then busy=0.
REQ-026 Auto mode with PERIOD_CYC=5000 and instant acks -> each measurement starts 5000 cycles after the previous DONE; a start pulse issued while busy produces no extra measurement.
REQ-027 Long ack: iic_ack held high for 50 cycles in WAIT_T -> a single capture, and GAP holds until ack falls.
REQ-028 Reset during WAIT_H -> all outputs take their reset values, no done pulse occurs, and a start after release runs a full measurement.
